// File: rtl/register_file_if.sv
// Bus bundle for the sixteen-entry register file: write port, two read
// ports, clear request and status.  The datapath side drives through the
// master modport; the register file attaches to the slave modport.
interface register_file_if #(
  parameter int WIDTH = 16
) ();
  logic [3:0]       wa;
  logic [WIDTH-1:0] wd;
  logic             we;
  logic [3:0]       ra0;
  logic [3:0]       ra1;
  logic [WIDTH-1:0] rd0;
  logic [WIDTH-1:0] rd1;
  logic             clr_req;
  logic             busy;
  logic             we_drop;

  modport master (
    output wa, wd, we, ra0, ra1, clr_req,
    input  rd0, rd1, busy, we_drop
  );

  modport slave (
    input  wa, wd, we, ra0, ra1, clr_req,
    output rd0, rd1, busy, we_drop
  );
endinterface

// File: rtl/register_file.sv
// Sixteen-entry WIDTH-bit general register file for the transputer datapath.
// One write port, two combinational read ports, and a sequential clear
// engine that zeroes one entry per cycle while refusing writes.
// Optional feature macro: RF_BYPASS_EN -- when defined, an accepted write is
// forwarded combinationally to any read port addressing the same entry.
module register_file #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  register_file_if.slave  bus
);

  typedef enum logic {READY, CLEAR} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             drop_reg;
  logic [WIDTH-1:0] regs [16];
  logic             busy;
  logic             wr_ok;

  assign busy  = (state_reg == CLEAR);
  assign wr_ok = bus.we && !busy;

  // Clear engine state and entry counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= READY;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state: start on request when idle, walk all 16 entries, then stop.
  // Requests arriving mid-clear are ignored so a clear is never restarted.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      READY: begin
        if (bus.clr_req) begin
          state_next = CLEAR;
          cnt_next   = 4'd0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd15) begin
          state_next = READY;
          cnt_next   = 4'd0;
        end
      end
      default: begin
        state_next = READY;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Storage: clearing owns the array while busy, otherwise accepted writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else if (busy) begin
      regs[cnt_reg] <= '0;
    end else if (wr_ok) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Refused-write flag: one cycle high for each write attempted while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_reg <= 1'b0;
    end else begin
      drop_reg <= bus.we && busy;
    end
  end

  assign bus.busy    = busy;
  assign bus.we_drop = drop_reg;

`ifdef RF_BYPASS_EN
  assign bus.rd0 = (wr_ok && (bus.ra0 == bus.wa)) ? bus.wd : regs[bus.ra0];
  assign bus.rd1 = (wr_ok && (bus.ra1 == bus.wa)) ? bus.wd : regs[bus.ra1];
`else
  assign bus.rd0 = regs[bus.ra0];
  assign bus.rd1 = regs[bus.ra1];
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model (array + remaining-clear-cycles countdown).
module tb_register_file;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 0;

  register_file_if #(.WIDTH(16)) bus ();

  register_file #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: contents, cycles of clearing left, drop flag.
  logic [15:0] mdl [16];
  int          clr_left;
  bit          mdl_drop;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
    clr_left = 0;
    mdl_drop = 0;
  endtask

  // One clock edge worth of behaviour, from the rules of operation.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (clr_left > 0) begin
      mdl[16 - clr_left] = 16'h0;
      mdl_drop = bus.we;
      clr_left = clr_left - 1;
    end else begin
      mdl_drop = 0;
      if (bus.we) mdl[bus.wa] = bus.wd;
      if (bus.clr_req) clr_left = 16;
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [3:0] ra);
`ifdef RF_BYPASS_EN
    if (bus.we && clr_left == 0 && ra == bus.wa) return bus.wd;
`endif
    return mdl[ra];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd0", {16'h0, bus.rd0}, {16'h0, model_rd(bus.ra0)});
      chk("rd1", {16'h0, bus.rd1}, {16'h0, model_rd(bus.ra1)});
      chk("busy", {31'h0, bus.busy}, {31'h0, clr_left > 0});
      chk("we_drop", {31'h0, bus.we_drop}, {31'h0, mdl_drop});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [3:0] ra0, input logic [3:0] ra1, input logic clr);
    bus.we = we; bus.wa = wa; bus.wd = wd;
    bus.ra0 = ra0; bus.ra1 = ra1; bus.clr_req = clr;
  endtask

  // Counts busy cycles from now, bounded so a stuck engine cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      n++;
      tick();
    end
  endtask

  int n_busy;

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive(0, 4'h0, 16'h0, 4'h3, 4'hF, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_drop", {31'h0, bus.we_drop}, 32'h0);
    chk("rst_rd0", {16'h0, bus.rd0}, 32'h0);
    chk("rst_rd1", {16'h0, bus.rd1}, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1;

    // Link register and entry 0 are plain registers.
    drive(1, 4'hD, 16'h1234, 4'h0, 4'h0, 0); tick();
    drive(1, 4'h0, 16'hBEEF, 4'h0, 4'h0, 0); tick();
    drive(0, 4'h0, 16'h0, 4'hD, 4'h0, 0); #1;
    chk("wr_d", {16'h0, bus.rd0}, 32'h1234);
    chk("wr_0", {16'h0, bus.rd1}, 32'hBEEF);

    // Same-cycle read of the write address.
    drive(1, 4'h3, 16'h0055, 4'h3, 4'h3, 0); tick();
    drive(1, 4'h3, 16'h00AA, 4'h3, 4'h0, 0); #1;
`ifdef RF_BYPASS_EN
    chk("same_cyc", {16'h0, bus.rd0}, 32'h00AA);
`else
    chk("same_cyc", {16'h0, bus.rd0}, 32'h0055);
`endif
    tick();
    drive(0, 4'h0, 16'h0, 4'h3, 4'h0, 0); #1;
    chk("next_cyc", {16'h0, bus.rd0}, 32'h00AA);

    // Fill, then clear with a refused write and an ignored request mid-clear.
    for (int i = 0; i < 16; i++) begin
      drive(1, i[3:0], 16'hFFFF, 4'h0, 4'h0, 0); tick();
    end
    drive(0, 4'h0, 16'h0, 4'h0, 4'h0, 1); tick();
    n_busy = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      n_busy++;
      drive(k == 4, 4'h5, 16'h7777, (k == 0) ? 4'h0 : 4'(k - 1), k[3:0], (k == 4 || k == 6));
      #1;
      if (k > 0) chk("clr_lo", {16'h0, bus.rd0}, 32'h0);
      chk("clr_hi", {16'h0, bus.rd1}, 32'hFFFF);
      if (k == 5) chk("drop_hi", {31'h0, bus.we_drop}, 32'h1);
      if (k == 6) chk("drop_lo", {31'h0, bus.we_drop}, 32'h0);
      tick();
    end
    chk("clr_len", n_busy, 32'd16);
    drive(0, 4'h0, 16'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 16; i++) begin
      bus.ra0 = i[3:0];
      #1;
      chk("clr_zero", {16'h0, bus.rd0}, 32'h0);
    end

    // Asynchronous reset in the middle of a clear.
    drive(1, 4'hC, 16'hABCD, 4'hC, 4'h0, 0); tick();
    drive(0, 4'h0, 16'h0, 4'hC, 4'h0, 1); tick();
    drive(0, 4'h0, 16'h0, 4'hC, 4'h0, 0);
    repeat (7) tick();
    chk("pre_rst", {16'h0, bus.rd0}, 32'hABCD);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", {31'h0, bus.busy}, 32'h0);
    chk("arst_rd", {16'h0, bus.rd0}, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(1, 4'h9, 16'h0101, 4'h9, 4'h0, 0); tick();
    drive(0, 4'h0, 16'h0, 4'h9, 4'h0, 0); #1;
    chk("post_rst_wr", {16'h0, bus.rd0}, 32'h0101);

    // Write and clear request on the same edge.
    drive(1, 4'h0, 16'h4321, 4'h0, 4'h0, 1); tick();
    drive(0, 4'h0, 16'h0, 4'h0, 4'h0, 0); #1;
    chk("simul_wr", {16'h0, bus.rd0}, 32'h4321);
    chk("simul_busy", {31'h0, bus.busy}, 32'h1);
    tick();
    chk("simul_clr", {16'h0, bus.rd0}, 32'h0);
    count_busy(n_busy);
    chk("simul_len", n_busy + 1, 32'd16);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 500; i++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      drive(1'($urandom % 2), wa, 16'($urandom),
            ($urandom % 3 == 0) ? wa : 4'($urandom_range(0, 15)),
            ($urandom % 3 == 0) ? wa : 4'($urandom_range(0, 15)),
            ($urandom % 40 == 0));
      tick();
    end
    drive(0, 4'h0, 16'h0, 4'h0, 4'h0, 0);
    tick();
    @(negedge clk);
    #1;
    chk_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
